cmplx_mult_sched: RTL and testbench
===================================

Name: cmplx_mult_sched

Overview:
- Twiddle-multiply scheduler for the FFT butterfly datapath.
- Computes one complex product (a_re + j·a_im)·(w_re + j·w_im) in Q7.8 sign-magnitude.
- Time-multiplexes a single shared fixed_point_math multiplier across the four real partial products, then combines them with a sign-magnitude adder.
- Sits between the butterfly address/data path and the butterfly add/subtract stage. Valid/ready on both sides.

Parameters:
- DATA_W, 16, word width. Only 16 is supported; it must match the multiplier.
- FRAC_W, 8, fraction bits. Only 8 is supported; documentary.
- SATURATE, 1:
  - 1 = clamp adder overflow to magnitude 0x7FFF.
  - 0 = drop the carry (wrap the magnitude).

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set this cycle
- a_re, a_im  in  16 each  data operand, sign-magnitude Q7.8
- w_re, w_im  in  16 each  twiddle operand, sign-magnitude Q7.8
- conj  in  1  use conj(w) for IFFT: w_im sign bit inverted at capture
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_re, out_im  out  16 each  result, sign-magnitude Q7.8
- out_sat  out  1  saturation or wrap occurred in out_re or out_im for this result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; in_ready = 1.
  - out_valid, out_re, out_im, out_sat, busy = 0.
  - Operand and product registers = 0.
- States: IDLE → MUL_RR → MUL_II → MUL_RI → MUL_IR → OUTPUT.
- Accept condition: in_valid && in_ready at a rising edge.
  - Operands are captured; w_im[15] is XORed with conj.
  - Next state is MUL_RR.
- in_ready = (state == IDLE) || (state == OUTPUT && out_ready).
- Multiplier inputs are muxed from the captured registers by state:
  - MUL_RR: a_re·w_re
  - MUL_II: a_im·w_im
  - MUL_RI: a_re·w_im
  - MUL_IR: a_im·w_re
- Products p_rr, p_ii, p_ri are registered at the end of their states.
- MUL_IR edge:
  - out_re = p_rr − p_ii.
  - out_im = p_ri + (multiplier output); this path is combinational, so no p_ir register.
  - out_sat is loaded; state → OUTPUT; out_valid = 1.
- Latency: out_valid is high 4 edges after the accept edge. Throughput is 1 result per 5 cycles with back-to-back accept.
- OUTPUT state:
  - out_* are held stable while out_ready = 0.
  - If out_ready = 1 and in_valid = 1: accept the new set and go to MUL_RR. out_valid drops.
  - If out_ready = 1 and in_valid = 0: go to IDLE. out_valid drops.
- Sign-magnitude add/sub. Subtraction = addition with the second operand's sign inverted.
  - Equal signs: magnitude = m1 + m2 in 16 bits. Bit15 set means overflow:
    - SATURATE = 1: magnitude 0x7FFF.
    - SATURATE = 0: keep the low 15 bits.
    - out_sat = 1 in either case.
  - Unequal signs: magnitude = |larger − smaller|; sign taken from the larger magnitude.
  - Zero result is always +0 (0x0000). A 0x8000 result is never emitted.
- The multiplier's own truncation of bits above 22 is inherited and is not flagged.
- Operands and the conj flag are frozen from capture until the next accept. Input changes mid-operation are ignored.
- Reset mid-operation: immediate return to IDLE. The in-flight result is discarded and no out_valid pulse appears after release.

Decomposition:
- Package fft_pkg:
  - Q7.8 constants: ONE = 16'h0100, MAG_MAX = 15'h7FFF, SIGN_BIT = 15.
  - sched_state_t enum.
  - sm_add function (sign-magnitude add returning {sat, result}), shared with the butterfly stage.
- Sub-module: one instance of fixed_point_math. The scheduler owns its operand mux.

Test Plan:
- Basic multiply:
  - Stimulus: a = (0x0100, 0x0000), w = (0x0080, 0x0080), conj = 0.
  - Response: out = (0x0080, 0x0080), out_sat = 0, out_valid exactly 4 cycles after accept.
- Cancellation to +0:
  - Stimulus: a = (0x0100, 0x0100), w = (0x0100, 0x0100).
  - Response: out_re = 0x0000 (not 0x8000), out_im = 0x0200.
- Conjugate:
  - Stimulus: same operands as cancellation, conj = 1.
  - Response: out_re = 0x0200, out_im = 0x0000.
- Saturation:
  - Stimulus: a = (0x4000, 0x4000), w = (0x0100, 0x8100).
  - Response: out_re = 0x7FFF, out_sat = 1, out_im = 0x0000.
  - Repeat with SATURATE = 0: out_re = 0x0000, out_sat = 1.
- Back-pressure:
  - Stimulus: hold out_ready = 0 for 3 cycles in OUTPUT.
  - Response: out_* stable and in_ready = 0 throughout.
  - Then raise out_ready with in_valid in the same cycle: new set accepted, out_valid low next cycle, next result 4 cycles later.
- Reset mid-operation:
  - Stimulus: assert n_rst in MUL_RI.
  - Response: all outputs 0 and busy = 0 immediately; in_ready = 1 after release; no out_valid for 10 idle cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath types, Q7.8 constants and the sign-magnitude adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam logic [15:0] ONE      = 16'h0100;
    localparam logic [14:0] MAG_MAX  = 15'h7FFF;
    localparam int          SIGN_BIT = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_RR = 3'd1,
        MUL_II = 3'd2,
        MUL_RI = 3'd3,
        MUL_IR = 3'd4,
        OUTPUT = 3'd5
    } sched_state_t;

    // Sign-magnitude add. Returns {sat, sign, magnitude}. A zero result is always +0.
    // Subtraction is done by the caller inverting the sign bit of y.
    function automatic logic [16:0] sm_add(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic        sat_en);
        logic [15:0] sum;
        logic [14:0] mag;
        logic        sgn;
        logic        sat;
        sum = {1'b0, x[SIGN_BIT-1:0]} + {1'b0, y[SIGN_BIT-1:0]};
        sat = 1'b0;
        if (x[SIGN_BIT] == y[SIGN_BIT]) begin
            sgn = x[SIGN_BIT];
            if (sum[15]) begin
                sat = 1'b1;
                mag = sat_en ? MAG_MAX : sum[14:0];
            end else begin
                mag = sum[14:0];
            end
        end else if (x[SIGN_BIT-1:0] >= y[SIGN_BIT-1:0]) begin
            sgn = x[SIGN_BIT];
            mag = x[SIGN_BIT-1:0] - y[SIGN_BIT-1:0];
        end else begin
            sgn = y[SIGN_BIT];
            mag = y[SIGN_BIT-1:0] - x[SIGN_BIT-1:0];
        end
        if (mag == 15'd0) begin
            sgn = 1'b0;
        end
        return {sat, sgn, mag};
    endfunction

endpackage

// File: rtl/fixed_point_math.sv
// Q7.8 sign-magnitude multiplier; magnitude bits above 22 of the raw product are dropped.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module fixed_point_math #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    logic [DATA_W-2:0] mag;

    // Full magnitude product, rescaled by the fraction width and truncated to 15 bits.
    assign mag = (DATA_W-1)'((2*(DATA_W-1))'(a[DATA_W-2:0]) * (2*(DATA_W-1))'(b[DATA_W-2:0]) >> FRAC_W);

    // A zero magnitude is always emitted as +0.
    assign p = (mag == '0) ? '0 : {a[DATA_W-1] ^ b[DATA_W-1], mag};

endmodule

// File: rtl/cmplx_mult_sched.sv
// Complex twiddle multiply over one shared multiplier, four partial products then combine.
// Latency: out_valid 4 cycles after accept; 1 result per 5 cycles back-to-back.
// Backpressure: in_ready low while computing; result held in OUTPUT until out_ready.
module cmplx_mult_sched
    import fft_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic              conj,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_sat,
    output logic              busy
);

    sched_state_t      state_q;
    sched_state_t      state_d;

    logic [DATA_W-1:0] a_re_q;
    logic [DATA_W-1:0] a_im_q;
    logic [DATA_W-1:0] w_re_q;
    logic [DATA_W-1:0] w_im_q;
    logic [DATA_W-1:0] p_rr_q;
    logic [DATA_W-1:0] p_ii_q;
    logic [DATA_W-1:0] p_ri_q;
    logic [DATA_W-1:0] out_re_q;
    logic [DATA_W-1:0] out_im_q;
    logic              out_sat_q;

    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_p;
    logic [16:0]       re_sum;
    logic [16:0]       im_sum;
    logic              accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == OUTPUT) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_sat   = out_sat_q;

    // Real part subtracts p_ii by flipping its sign; the imaginary part takes the
    // fourth product straight off the multiplier, so it never needs a register.
    assign re_sum = sm_add(p_rr_q, p_ii_q ^ {1'b1, {(DATA_W-1){1'b0}}}, SATURATE);
    assign im_sum = sm_add(p_ri_q, mul_p, SATURATE);

    // Steer the captured operands into the shared multiplier by phase.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_RR: begin mul_a = a_re_q; mul_b = w_re_q; end
            MUL_II: begin mul_a = a_im_q; mul_b = w_im_q; end
            MUL_RI: begin mul_a = a_re_q; mul_b = w_im_q; end
            MUL_IR: begin mul_a = a_im_q; mul_b = w_re_q; end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    fixed_point_math #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Sequence the four multiply phases, then hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL_RR;
            MUL_RR:  state_d = MUL_II;
            MUL_II:  state_d = MUL_RI;
            MUL_RI:  state_d = MUL_IR;
            MUL_IR:  state_d = OUTPUT;
            OUTPUT:  if (out_ready) state_d = in_valid ? MUL_RR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight product.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture (with conjugation), partial-product and result registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_re_q    <= '0;
            a_im_q    <= '0;
            w_re_q    <= '0;
            w_im_q    <= '0;
            p_rr_q    <= '0;
            p_ii_q    <= '0;
            p_ri_q    <= '0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_sat_q <= 1'b0;
        end else begin
            if (accept) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                w_re_q <= w_re;
                w_im_q <= {w_im[DATA_W-1] ^ conj, w_im[DATA_W-2:0]};
            end
            case (state_q)
                MUL_RR: p_rr_q <= mul_p;
                MUL_II: p_ii_q <= mul_p;
                MUL_RI: p_ri_q <= mul_p;
                MUL_IR: begin
                    out_re_q  <= re_sum[15:0];
                    out_im_q  <= im_sum[15:0];
                    out_sat_q <= re_sum[16] | im_sum[16];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmplx_mult_sched.sv
// Bench for cmplx_mult_sched: two instances (saturating and wrapping) under shared stimulus.
// Latency: checks 4-cycle accept-to-valid and 5-cycle back-to-back cadence.
// Backpressure: holds out_ready low in OUTPUT and checks results stay put.
module tb_cmplx_mult_sched;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic [15:0] a_re, a_im, w_re, w_im;
    logic        conj;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_sat1, busy1;
    logic [15:0] out_re1, out_im1;
    logic        in_ready0, out_valid0, out_sat0, busy0;
    logic [15:0] out_re0, out_im0;

    int n_chk  = 0;
    int n_pass = 0;

    cmplx_mult_sched #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im), .conj(conj),
        .out_valid(out_valid1), .out_ready(out_ready), .out_re(out_re1),
        .out_im(out_im1), .out_sat(out_sat1), .busy(busy1)
    );

    cmplx_mult_sched #(.SATURATE(1'b0)) dut_wrap (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im), .conj(conj),
        .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0),
        .out_im(out_im0), .out_sat(out_sat0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sm_val(input logic [15:0] v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    // Real-valued Q7.8 product, magnitude truncated to 15 bits.
    function automatic longint q_mul(input logic [15:0] x, input logic [15:0] y);
        longint m;
        m = ((longint'(x[14:0]) * longint'(y[14:0])) / 256) % 32768;
        return (x[15] ^ y[15]) ? -m : m;
    endfunction

    // Encode an integer sum back to sign-magnitude, flagging overflow: {sat, value}.
    function automatic logic [16:0] q_pack(input longint v, input bit sat_en);
        longint   mag;
        logic [14:0] m15;
        bit       s;
        mag = (v < 0) ? -v : v;
        s   = 1'b0;
        if (mag > 32767) begin
            s   = 1'b1;
            mag = sat_en ? 32767 : (mag % 32768);
        end
        m15 = mag[14:0];
        if (mag == 0) return {s, 16'h0000};
        return {s, (v < 0) ? 1'b1 : 1'b0, m15};
    endfunction

    bit          m_pend, m_valid;
    longint      m_cyc, m_due;
    logic [16:0] pr1, pi1, pr0, pi0;
    logic [16:0] er1, ei1, er0, ei0;

    initial begin
        m_pend = 0; m_valid = 0; m_cyc = 0; m_due = 0;
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                m_pend = 0; m_valid = 0;
            end else begin
                bit     rdy;
                logic [15:0] wi;
                longint vre, vim;
                m_cyc++;
                rdy = !(m_pend || m_valid) || (m_valid && out_ready);
                if (m_valid && out_ready) m_valid = 0;
                if (in_valid && rdy) begin
                    wi  = w_im ^ {conj, 15'h0000};
                    vre = q_mul(a_re, w_re) - q_mul(a_im, wi);
                    vim = q_mul(a_re, wi) + q_mul(a_im, w_re);
                    pr1 = q_pack(vre, 1'b1); pi1 = q_pack(vim, 1'b1);
                    pr0 = q_pack(vre, 1'b0); pi0 = q_pack(vim, 1'b0);
                    m_pend = 1;
                    m_due  = m_cyc + 4;
                end
                if (m_pend && m_cyc == m_due) begin
                    m_pend = 0; m_valid = 1;
                    er1 = pr1; ei1 = pi1; er0 = pr0; ei0 = pi0;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("valid_s", {31'd0, out_valid1}, {31'd0, m_valid});
            check("valid_w", {31'd0, out_valid0}, {31'd0, m_valid});
            check("busy_s", {31'd0, busy1}, {31'd0, m_pend | m_valid});
            check("busy_w", {31'd0, busy0}, {31'd0, m_pend | m_valid});
            check("rdy_s", {31'd0, in_ready1}, {31'd0, !(m_pend || m_valid) || (m_valid && out_ready)});
            check("rdy_w", {31'd0, in_ready0}, {31'd0, !(m_pend || m_valid) || (m_valid && out_ready)});
            if (m_valid) begin
                check("re_s", {16'd0, out_re1}, {16'd0, er1[15:0]});
                check("im_s", {16'd0, out_im1}, {16'd0, ei1[15:0]});
                check("sat_s", {31'd0, out_sat1}, {31'd0, er1[16] | ei1[16]});
                check("re_w", {16'd0, out_re0}, {16'd0, er0[15:0]});
                check("im_w", {16'd0, out_im0}, {16'd0, ei0[15:0]});
                check("sat_w", {31'd0, out_sat0}, {31'd0, er0[16] | ei0[16]});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic set_ops(input logic [15:0] ar, ai, wr, wi, input logic cj);
        a_re = ar; a_im = ai; w_re = wr; w_im = wi; conj = cj;
    endtask

    task automatic scramble;
        set_ops(16'hFFFF, 16'h7FFF, 16'h8001, 16'h1234, 1'b1);
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_one(input string nm, input logic [15:0] ar, ai, wr, wi, input logic cj,
                           input logic [15:0] e_re, e_im, input logic e_sat,
                           input logic [15:0] e_re0, e_im0, input logic e_sat0);
        int lat;
        set_ops(ar, ai, wr, wi, cj);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_valid(lat);
        check({nm, "_lat"}, lat, 4);
        check({nm, "_re"}, {16'd0, out_re1}, {16'd0, e_re});
        check({nm, "_im"}, {16'd0, out_im1}, {16'd0, e_im});
        check({nm, "_sat"}, {31'd0, out_sat1}, {31'd0, e_sat});
        check({nm, "_re_wrap"}, {16'd0, out_re0}, {16'd0, e_re0});
        check({nm, "_im_wrap"}, {16'd0, out_im0}, {16'd0, e_im0});
        check({nm, "_sat_wrap"}, {31'd0, out_sat0}, {31'd0, e_sat0});
        pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_ops(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid1}, 0);
        check("rst_busy", {31'd0, busy1}, 0);
        check("rst_ready", {31'd0, in_ready1}, 1);
        check("rst_re", {16'd0, out_re1}, 0);
        check("rst_sat", {31'd0, out_sat0}, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        run_one("basic", 16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0,
                16'h0080, 16'h0080, 1'b0, 16'h0080, 16'h0080, 1'b0);
        run_one("cancel", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0,
                16'h0000, 16'h0200, 1'b0, 16'h0000, 16'h0200, 1'b0);
        run_one("conj", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1,
                16'h0200, 16'h0000, 1'b0, 16'h0200, 16'h0000, 1'b0);
        run_one("satur", 16'h4000, 16'h4000, 16'h0100, 16'h8100, 1'b0,
                16'h7FFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1);
        // (-1)*2 on the real part; the -1 * +0 partial product must come out as +0.
        run_one("neg", 16'h8100, 16'h0000, 16'h0200, 16'h0000, 1'b0,
                16'h8200, 16'h0000, 1'b0, 16'h8200, 16'h0000, 1'b0);

        // Back-pressure: hold the result for 3 cycles, then accept a new set in the release cycle.
        set_ops(16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_valid(lat);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, out_valid1}, 1);
            check("bp_hold_re", {16'd0, out_re1}, 32'h0080);
            check("bp_hold_im", {16'd0, out_im1}, 32'h0080);
            check("bp_hold_ready", {31'd0, in_ready1}, 0);
            @(posedge clk); #1;
        end
        // (3 - j1) * (0.5 + j1) = 1.5 + 1 + j(3 - 0.5) = 2.5 + j2.5
        set_ops(16'h0300, 16'h8100, 16'h0080, 16'h0100, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();
        check("bp_drop_valid", {31'd0, out_valid1}, 0);
        wait_valid(lat);
        check("bp_next_lat", lat, 4);
        check("bp_next_re", {16'd0, out_re1}, 32'h0280);
        check("bp_next_im", {16'd0, out_im1}, 32'h0280);
        pop();

        // Reset while in MUL_RI.
        set_ops(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check("mrst_valid", {31'd0, out_valid1}, 0);
        check("mrst_busy", {31'd0, busy1}, 0);
        check("mrst_re", {16'd0, out_re1}, 0);
        check("mrst_im", {16'd0, out_im1}, 0);
        check("mrst_sat", {31'd0, out_sat1}, 0);
        check("mrst_busy_w", {31'd0, busy0}, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        check("mrst_ready", {31'd0, in_ready1}, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("mrst_idle_valid", {31'd0, out_valid1 | out_valid0}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
